mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mem_access_stage.sv | 146 ++++++++++++++
 tb/tb_mem_access_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage access controller: default widths,
// FSM state encoding and the timeout counter width helper.
package mem_access_stage_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold TIMEOUT-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for the WAIT state: synchronous clear, count enable and a
// terminal-count flag raised while the count equals TIMEOUT-1.
module mem_timeout_ctr
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int                 CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]   TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues loads/stores on a single-outstanding,
// variable-latency bus, stalls the front end and bubbles MEM/WB meanwhile.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                REG_W    = DEF_REG_W,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] pcplus1,
    input  logic [REG_W-1:0]  destreg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              ResultSrc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] pcplus1_o,
    output logic [REG_W-1:0]  destreg_o,
    output logic              RegWrite_o,
    output logic              ResultSrc_o,
    output logic              bus_err
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] rd_q;
    logic              memop;
    logic              start;
    logic              ack_take;
    logic              timed_out;
    logic              stall;
    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_tc;

    assign memop = MemRead | MemWrite;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ctr_clr),
        .enable  (ctr_en),
        .tc      (ctr_tc)
    );

    // Next state, stall and the MEM/WB output mux. EX/MEM is frozen while
    // stalled, so in DONE the inputs still describe the completed access.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        start       = 1'b0;
        ack_take    = 1'b0;
        timed_out   = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        ReadData_o  = '0;
        ALUResult_o = ALUResult;
        pcplus1_o   = pcplus1;
        destreg_o   = destreg;
        RegWrite_o  = RegWrite;
        ResultSrc_o = ResultSrc;

        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    stall       = 1'b1;
                    start       = 1'b1;
                    ctr_clr     = 1'b1;
                    RegWrite_o  = 1'b0;
                    ResultSrc_o = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall       = 1'b1;
                ctr_en      = 1'b1;
                RegWrite_o  = 1'b0;
                ResultSrc_o = 1'b0;
                // An ack on the terminal cycle still counts as success.
                if (mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_DONE;
                end else if (ctr_tc) begin
                    timed_out = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                ReadData_o = MemWrite ? '0 : rd_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // No stall can be requested while the controller is held in reset.
    assign stall_o = reset_n & stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
            bus_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= ALUResult[ADDR_W-1:0];
                mem_wdata <= WriteData;
            end
            if (ack_take) begin
                rd_q    <= mem_rdata;
                mem_req <= 1'b0;
            end
            if (timed_out) begin
                rd_q    <= ERR_DATA;
                bus_err <= 1'b1;
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load, store,
// back-to-back loads with ack/timeout collision, timeout abort, reset mid-access.
module tb_mem_access_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ALUResult;
    logic [7:0] WriteData;
    logic [7:0] pcplus1;
    logic [2:0] destreg;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       ResultSrc;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       stall_o;
    logic [7:0] ReadData_o;
    logic [7:0] ALUResult_o;
    logic [7:0] pcplus1_o;
    logic [2:0] destreg_o;
    logic       RegWrite_o;
    logic       ResultSrc_o;
    logic       bus_err;

    int passed = 0;
    int total  = 0;

    mem_access_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .pcplus1     (pcplus1),
        .destreg     (destreg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_o     (stall_o),
        .ReadData_o  (ReadData_o),
        .ALUResult_o (ALUResult_o),
        .pcplus1_o   (pcplus1_o),
        .destreg_o   (destreg_o),
        .RegWrite_o  (RegWrite_o),
        .ResultSrc_o (ResultSrc_o),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_instr(input logic mr, input logic mw, input logic rw, input logic rs,
                             input logic [7:0] alu, input logic [7:0] wd,
                             input logic [7:0] pc, input logic [2:0] dr);
        MemRead   = mr;
        MemWrite  = mw;
        RegWrite  = rw;
        ResultSrc = rs;
        ALUResult = alu;
        WriteData = wd;
        pcplus1   = pc;
        destreg   = dr;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
        repeat (3) @(posedge clk);
        #2;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
        total++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h want 00", mem_addr); else passed++;
        total++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
        reset_n = 1'b1;
        next_cycle; settle;
        total++; if (stall_o !== 1'b0) $display("FAIL post_reset_stall: got %b want 0", stall_o); else passed++;
        total++; if (ReadData_o !== 8'h00) $display("FAIL post_reset_rdata: got %h want 00", ReadData_o); else passed++;
    endtask

    task automatic test_alu;
        next_cycle;
        set_instr(0, 0, 1, 0, 8'h3C, 8'h00, 8'h08, 3'd3);
        settle;
        total++; if (RegWrite_o !== 1'b1) $display("FAIL alu_regwrite: got %b want 1", RegWrite_o); else passed++;
        total++; if (ALUResult_o !== 8'h3C) $display("FAIL alu_result: got %h want 3c", ALUResult_o); else passed++;
        total++; if (destreg_o !== 3'd3) $display("FAIL alu_destreg: got %0d want 3", destreg_o); else passed++;
        total++; if (pcplus1_o !== 8'h08) $display("FAIL alu_pcplus1: got %h want 08", pcplus1_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_o); else passed++;
        total++; if (ReadData_o !== 8'h00) $display("FAIL alu_rdata: got %h want 00", ReadData_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL alu_mem_req: got %b want 0", mem_req); else passed++;
        // Same cycle, different pattern: pass-through is purely combinational.
        set_instr(0, 0, 0, 1, 8'hC3, 8'h00, 8'h09, 3'd7);
        settle;
        total++; if (RegWrite_o !== 1'b0) $display("FAIL alu2_regwrite: got %b want 0", RegWrite_o); else passed++;
        total++; if (ALUResult_o !== 8'hC3) $display("FAIL alu2_result: got %h want c3", ALUResult_o); else passed++;
        total++; if (ResultSrc_o !== 1'b1) $display("FAIL alu2_resultsrc: got %b want 1", ResultSrc_o); else passed++;
        total++; if (destreg_o !== 3'd7) $display("FAIL alu2_destreg: got %0d want 7", destreg_o); else passed++;
    endtask

    task automatic test_load;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h10, 8'h00, 8'h11, 3'd5);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL load_idle_stall: got %b want 1", stall_o); else passed++;
        total++; if (RegWrite_o !== 1'b0) $display("FAIL load_idle_bubble: got %b want 0", RegWrite_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL load_idle_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL load_wait_stall: got %b want 1", stall_o); else passed++;
        total++; if (mem_req !== 1'b1) $display("FAIL load_wait_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL load_wait_we: got %b want 0", mem_we); else passed++;
        total++; if (mem_addr !== 8'h10) $display("FAIL load_wait_addr: got %h want 10", mem_addr); else passed++;
        total++; if (RegWrite_o !== 1'b0) $display("FAIL load_wait_bubble: got %b want 0", RegWrite_o); else passed++;
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        settle;
        total++; if (stall_o !== 1'b0) $display("FAIL load_done_stall: got %b want 0", stall_o); else passed++;
        total++; if (ReadData_o !== 8'hA5) $display("FAIL load_done_rdata: got %h want a5", ReadData_o); else passed++;
        total++; if (RegWrite_o !== 1'b1) $display("FAIL load_done_regwrite: got %b want 1", RegWrite_o); else passed++;
        total++; if (ResultSrc_o !== 1'b1) $display("FAIL load_done_resultsrc: got %b want 1", ResultSrc_o); else passed++;
        total++; if (destreg_o !== 3'd5) $display("FAIL load_done_destreg: got %0d want 5", destreg_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL load_done_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
        settle;
        total++; if (RegWrite_o !== 1'b0) $display("FAIL load_after_regwrite: got %b want 0", RegWrite_o); else passed++;
        total++; if (ReadData_o !== 8'h00) $display("FAIL load_after_rdata: got %h want 00", ReadData_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL load_after_stall: got %b want 0", stall_o); else passed++;
    endtask

    task automatic test_store;
        next_cycle;
        set_instr(0, 1, 0, 0, 8'h20, 8'h5A, 8'h12, 3'd2);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL store_idle_stall: got %b want 1", stall_o); else passed++;
        for (int i = 0; i < 4; i++) begin
            next_cycle;
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 8'h77;
            end
            settle;
            total++; if (mem_req !== 1'b1) $display("FAIL store_req[%0d]: got %b want 1", i, mem_req); else passed++;
            total++; if (mem_we !== 1'b1) $display("FAIL store_we[%0d]: got %b want 1", i, mem_we); else passed++;
            total++; if (mem_addr !== 8'h20) $display("FAIL store_addr[%0d]: got %h want 20", i, mem_addr); else passed++;
            total++; if (mem_wdata !== 8'h5A) $display("FAIL store_wdata[%0d]: got %h want 5a", i, mem_wdata); else passed++;
            total++; if (stall_o !== 1'b1) $display("FAIL store_stall[%0d]: got %b want 1", i, stall_o); else passed++;
            total++; if (RegWrite_o !== 1'b0) $display("FAIL store_regwrite[%0d]: got %b want 0", i, RegWrite_o); else passed++;
        end
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        settle;
        total++; if (stall_o !== 1'b0) $display("FAIL store_done_stall: got %b want 0", stall_o); else passed++;
        total++; if (RegWrite_o !== 1'b0) $display("FAIL store_done_regwrite: got %b want 0", RegWrite_o); else passed++;
        total++; if (ReadData_o !== 8'h00) $display("FAIL store_done_rdata: got %h want 00", ReadData_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL store_done_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    endtask

    task automatic test_back_to_back;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h30, 8'h00, 8'h13, 3'd1);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL b2b1_idle_stall: got %b want 1", stall_o); else passed++;
        // Ack arrives on the 16th WAIT cycle, the same cycle the timeout fires.
        for (int i = 0; i < 16; i++) begin
            next_cycle;
            if (i == 15) begin
                mem_ack = 1'b1; mem_rdata = 8'h3E;
            end
            settle;
            total++; if (stall_o !== 1'b1) $display("FAIL b2b1_wait_stall[%0d]: got %b want 1", i, stall_o); else passed++;
        end
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        settle;
        total++; if (ReadData_o !== 8'h3E) $display("FAIL b2b1_done_rdata: got %h want 3e", ReadData_o); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL b2b1_done_bus_err: got %b want 0", bus_err); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL b2b1_done_stall: got %b want 0", stall_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL b2b1_done_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h31, 8'h00, 8'h14, 3'd2);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL b2b2_idle_stall: got %b want 1", stall_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL b2b2_idle_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        mem_ack = 1'b1; mem_rdata = 8'h4F;
        settle;
        total++; if (mem_req !== 1'b1) $display("FAIL b2b2_wait_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_addr !== 8'h31) $display("FAIL b2b2_wait_addr: got %h want 31", mem_addr); else passed++;
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        settle;
        total++; if (ReadData_o !== 8'h4F) $display("FAIL b2b2_done_rdata: got %h want 4f", ReadData_o); else passed++;
        total++; if (destreg_o !== 3'd2) $display("FAIL b2b2_done_destreg: got %0d want 2", destreg_o); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL b2b2_done_bus_err: got %b want 0", bus_err); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL b2b2_done_stall: got %b want 0", stall_o); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    endtask

    task automatic test_timeout;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h40, 8'h00, 8'h15, 3'd6);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL tmo_idle_stall: got %b want 1", stall_o); else passed++;
        for (int i = 0; i < 16; i++) begin
            next_cycle; settle;
            total++; if (mem_req !== 1'b1) $display("FAIL tmo_wait_req[%0d]: got %b want 1", i, mem_req); else passed++;
            total++; if (stall_o !== 1'b1) $display("FAIL tmo_wait_stall[%0d]: got %b want 1", i, stall_o); else passed++;
        end
        next_cycle;
        mem_ack = 1'b1; mem_rdata = 8'h12;
        settle;
        total++; if (mem_req !== 1'b0) $display("FAIL tmo_done_req: got %b want 0", mem_req); else passed++;
        total++; if (ReadData_o !== 8'hFF) $display("FAIL tmo_done_rdata: got %h want ff", ReadData_o); else passed++;
        total++; if (bus_err !== 1'b1) $display("FAIL tmo_done_bus_err: got %b want 1", bus_err); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL tmo_done_stall: got %b want 0", stall_o); else passed++;
        total++; if (RegWrite_o !== 1'b1) $display("FAIL tmo_done_regwrite: got %b want 1", RegWrite_o); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
        settle;
        total++; if (stall_o !== 1'b0) $display("FAIL tmo_late_ack_stall: got %b want 0", stall_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL tmo_late_ack_req: got %b want 0", mem_req); else passed++;
        total++; if (ReadData_o !== 8'h00) $display("FAIL tmo_late_ack_rdata: got %h want 00", ReadData_o); else passed++;
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        set_instr(0, 0, 1, 0, 8'h55, 8'h00, 8'h17, 3'd4);
        settle;
        total++; if (bus_err !== 1'b1) $display("FAIL tmo_sticky_bus_err: got %b want 1", bus_err); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL tmo_after_stall: got %b want 0", stall_o); else passed++;
        total++; if (ALUResult_o !== 8'h55) $display("FAIL tmo_after_alu: got %h want 55", ALUResult_o); else passed++;
    endtask

    task automatic test_reset_mid;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h50, 8'h00, 8'h16, 3'd7);
        next_cycle; settle;
        total++; if (mem_req !== 1'b1) $display("FAIL rstmid_wait_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_addr !== 8'h50) $display("FAIL rstmid_wait_addr: got %h want 50", mem_addr); else passed++;
        #1 reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", mem_req); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall_o); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL rstmid_bus_err: got %b want 0", bus_err); else passed++;
        total++; if (mem_addr !== 8'h00) $display("FAIL rstmid_addr: got %h want 00", mem_addr); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
        #3 reset_n = 1'b1;
        next_cycle;
        set_instr(0, 0, 1, 0, 8'h66, 8'h00, 8'h18, 3'd1);
        settle;
        total++; if (stall_o !== 1'b0) $display("FAIL rstmid_after_stall: got %b want 0", stall_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rstmid_after_req: got %b want 0", mem_req); else passed++;
        total++; if (RegWrite_o !== 1'b1) $display("FAIL rstmid_after_regwrite: got %b want 1", RegWrite_o); else passed++;
        total++; if (ALUResult_o !== 8'h66) $display("FAIL rstmid_after_alu: got %h want 66", ALUResult_o); else passed++;
        next_cycle;
        set_instr(1, 0, 1, 1, 8'h70, 8'h00, 8'h19, 3'd3);
        settle;
        total++; if (stall_o !== 1'b1) $display("FAIL rstmid_load_stall: got %b want 1", stall_o); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rstmid_load_idle_req: got %b want 0", mem_req); else passed++;
        next_cycle;
        mem_ack = 1'b1; mem_rdata = 8'h9C;
        settle;
        total++; if (mem_req !== 1'b1) $display("FAIL rstmid_load_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_addr !== 8'h70) $display("FAIL rstmid_load_addr: got %h want 70", mem_addr); else passed++;
        next_cycle;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        settle;
        total++; if (ReadData_o !== 8'h9C) $display("FAIL rstmid_load_rdata: got %h want 9c", ReadData_o); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL rstmid_load_bus_err: got %b want 0", bus_err); else passed++;
        next_cycle;
        set_instr(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
